// File: rtl/ucode_pkg.sv
// Shared types and instruction field layout for the microcoded register-file/ALU controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ucode_pkg;

  localparam int OP_W = 3;

  localparam int DEF_REG_ADDR_W = 3;
  localparam int DEF_ALUOP_W    = 2;
  localparam int DEF_PROG_DEPTH = 16;
  localparam int DEF_PC_W       = $clog2(DEF_PROG_DEPTH);

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_LDI1 = 3'd1,
    OP_ALU  = 3'd2,
    OP_OUT  = 3'd3,
    OP_BLTE = 3'd4,
    OP_BZ   = 3'd5,
    OP_JMP  = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Word layout, MSB to LSB: op | waddr | raddr1 | raddr2 | aluop | target
  function automatic int aluop_lsb(input int pc_w);
    return pc_w;
  endfunction

  function automatic int raddr2_lsb(input int reg_addr_w, input int aluop_w, input int pc_w);
    return aluop_lsb(pc_w) + aluop_w + 0 * reg_addr_w;
  endfunction

  function automatic int raddr1_lsb(input int reg_addr_w, input int aluop_w, input int pc_w);
    return raddr2_lsb(reg_addr_w, aluop_w, pc_w) + reg_addr_w;
  endfunction

  function automatic int waddr_lsb(input int reg_addr_w, input int aluop_w, input int pc_w);
    return raddr1_lsb(reg_addr_w, aluop_w, pc_w) + reg_addr_w;
  endfunction

  function automatic int op_lsb(input int reg_addr_w, input int aluop_w, input int pc_w);
    return waddr_lsb(reg_addr_w, aluop_w, pc_w) + reg_addr_w;
  endfunction

  function automatic int instr_width(input int reg_addr_w, input int aluop_w, input int pc_w);
    return op_lsb(reg_addr_w, aluop_w, pc_w) + OP_W;
  endfunction

  localparam int DEF_INSTR_W = instr_width(DEF_REG_ADDR_W, DEF_ALUOP_W, DEF_PC_W);

endpackage

// File: rtl/ucode_control_unit_if.sv
// Control/handshake bundle between a host/datapath and ucode_control_unit; step exists only with UCODE_STEP_EN.
// Latency: n/a (wires only).
// Backpressure: n/a; step (when built) is the only stall input.
interface ucode_control_unit_if
  import ucode_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int ALUOP_W    = 2,
  parameter int PROG_DEPTH = 16
);
  localparam int PC_W    = $clog2(PROG_DEPTH);
  localparam int INSTR_W = instr_width(REG_ADDR_W, ALUOP_W, PC_W);

  logic                  start;
  logic                  abort;
  logic                  prog_we;
  logic [PC_W-1:0]       prog_addr;
  logic [INSTR_W-1:0]    prog_wdata;
  logic                  lte;
  logic                  zero;
  logic                  busy;
  logic                  done;
  logic [PC_W-1:0]       pc;
  logic                  RFSrcMuxSel;
  logic [REG_ADDR_W-1:0] RAddr1;
  logic [REG_ADDR_W-1:0] RAddr2;
  logic [REG_ADDR_W-1:0] WAddr;
  logic                  we;
  logic                  OutPortEn;
  logic [ALUOP_W-1:0]    ALUop;

`ifdef UCODE_STEP_EN
  logic                  step;

  modport master (
    output start, abort, prog_we, prog_addr, prog_wdata, lte, zero, step,
    input  busy, done, pc, RFSrcMuxSel, RAddr1, RAddr2, WAddr, we, OutPortEn, ALUop
  );
  modport slave (
    input  start, abort, prog_we, prog_addr, prog_wdata, lte, zero, step,
    output busy, done, pc, RFSrcMuxSel, RAddr1, RAddr2, WAddr, we, OutPortEn, ALUop
  );
`else
  modport master (
    output start, abort, prog_we, prog_addr, prog_wdata, lte, zero,
    input  busy, done, pc, RFSrcMuxSel, RAddr1, RAddr2, WAddr, we, OutPortEn, ALUop
  );
  modport slave (
    input  start, abort, prog_we, prog_addr, prog_wdata, lte, zero,
    output busy, done, pc, RFSrcMuxSel, RAddr1, RAddr2, WAddr, we, OutPortEn, ALUop
  );
`endif

endinterface

// File: rtl/ucode_decoder.sv
// Combinational micro-instruction decode: word + lte/zero flags -> datapath controls, branch, halt.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller gates outputs by FSM state and step.
module ucode_decoder
  import ucode_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int ALUOP_W    = 2,
  parameter int PC_W       = 4,
  localparam int INSTR_W   = instr_width(REG_ADDR_W, ALUOP_W, PC_W)
) (
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  lte,
  input  logic                  zero,
  output logic                  RFSrcMuxSel,
  output logic [REG_ADDR_W-1:0] RAddr1,
  output logic [REG_ADDR_W-1:0] RAddr2,
  output logic [REG_ADDR_W-1:0] WAddr,
  output logic                  we,
  output logic                  OutPortEn,
  output logic [ALUOP_W-1:0]    ALUop,
  output logic [PC_W-1:0]       target,
  output logic                  branch_taken,
  output logic                  is_halt
);
  localparam int ALU_LSB = aluop_lsb(PC_W);
  localparam int RA2_LSB = raddr2_lsb(REG_ADDR_W, ALUOP_W, PC_W);
  localparam int RA1_LSB = raddr1_lsb(REG_ADDR_W, ALUOP_W, PC_W);
  localparam int WA_LSB  = waddr_lsb(REG_ADDR_W, ALUOP_W, PC_W);
  localparam int OP_LSB  = op_lsb(REG_ADDR_W, ALUOP_W, PC_W);

  op_e                   op;
  logic [REG_ADDR_W-1:0] f_waddr;
  logic [REG_ADDR_W-1:0] f_raddr1;
  logic [REG_ADDR_W-1:0] f_raddr2;
  logic [ALUOP_W-1:0]    f_aluop;

  assign op       = op_e'(instr[OP_LSB +: OP_W]);
  assign f_waddr  = instr[WA_LSB  +: REG_ADDR_W];
  assign f_raddr1 = instr[RA1_LSB +: REG_ADDR_W];
  assign f_raddr2 = instr[RA2_LSB +: REG_ADDR_W];
  assign f_aluop  = instr[ALU_LSB +: ALUOP_W];
  assign target   = instr[PC_W-1:0];

  // Fields an opcode does not use stay at 0 so the datapath sees clean controls.
  always_comb begin
    RFSrcMuxSel  = 1'b0;
    RAddr1       = '0;
    RAddr2       = '0;
    WAddr        = '0;
    we           = 1'b0;
    OutPortEn    = 1'b0;
    ALUop        = '0;
    branch_taken = 1'b0;
    is_halt      = 1'b0;
    case (op)
      OP_LDI1: begin
        RFSrcMuxSel = 1'b1;
        we          = 1'b1;
        WAddr       = f_waddr;
      end
      OP_ALU: begin
        we     = 1'b1;
        WAddr  = f_waddr;
        RAddr1 = f_raddr1;
        RAddr2 = f_raddr2;
        ALUop  = f_aluop;
      end
      OP_OUT: begin
        OutPortEn = 1'b1;
        RAddr1    = f_raddr1;
      end
      OP_BLTE: begin
        RAddr1       = f_raddr1;
        RAddr2       = f_raddr2;
        branch_taken = lte;
      end
      OP_BZ: begin
        RAddr1       = f_raddr1;
        RAddr2       = f_raddr2;
        ALUop        = f_aluop;
        branch_taken = zero;
      end
      OP_JMP:  branch_taken = 1'b1;
      OP_HALT: is_halt      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ucode_control_unit.sv
// Microcoded register-file/ALU controller: loadable store, one instruction per cycle, start/busy/done/abort; UCODE_STEP_EN adds a step gate.
// Latency: start at edge N drives instruction 0 in cycle N+1; branches take no bubble.
// Backpressure: none by default; with UCODE_STEP_EN an instruction retires only when step=1.
module ucode_control_unit
  import ucode_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int ALUOP_W    = 2,
  parameter int PROG_DEPTH = 16
) (
  input logic                clk,
  input logic                reset_n,
  ucode_control_unit_if.slave bus
);
  localparam int PC_W    = $clog2(PROG_DEPTH);
  localparam int INSTR_W = instr_width(REG_ADDR_W, ALUOP_W, PC_W);

  state_e                state;
  logic [PC_W-1:0]       pc;
  logic                  busy_q;
  logic                  done_q;
  logic [INSTR_W-1:0]    store [PROG_DEPTH];
  logic [INSTR_W-1:0]    instr;

  logic                  d_rfsel;
  logic [REG_ADDR_W-1:0] d_raddr1;
  logic [REG_ADDR_W-1:0] d_raddr2;
  logic [REG_ADDR_W-1:0] d_waddr;
  logic                  d_we;
  logic                  d_oe;
  logic [ALUOP_W-1:0]    d_aluop;
  logic [PC_W-1:0]       d_target;
  logic                  d_taken;
  logic                  d_halt;
  logic                  exec;
  logic                  retire;

  // Store has no reset so a program survives reset_n; writes only land while idle.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state == ST_IDLE) begin
      store[bus.prog_addr] <= bus.prog_wdata;
    end
  end

  assign instr = store[pc];

  ucode_decoder #(
    .REG_ADDR_W (REG_ADDR_W),
    .ALUOP_W    (ALUOP_W),
    .PC_W       (PC_W)
  ) u_dec (
    .instr        (instr),
    .lte          (bus.lte),
    .zero         (bus.zero),
    .RFSrcMuxSel  (d_rfsel),
    .RAddr1       (d_raddr1),
    .RAddr2       (d_raddr2),
    .WAddr        (d_waddr),
    .we           (d_we),
    .OutPortEn    (d_oe),
    .ALUop        (d_aluop),
    .target       (d_target),
    .branch_taken (d_taken),
    .is_halt      (d_halt)
  );

  assign exec = (state == ST_EXEC);
`ifdef UCODE_STEP_EN
  assign retire = exec & bus.step;
`else
  assign retire = exec;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      pc     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= ST_EXEC;
            pc     <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            pc     <= '0;
            busy_q <= 1'b0;
          end else if (retire) begin
            if (d_halt) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              // pc+1 wraps naturally because PROG_DEPTH is a power of two.
              pc <= d_taken ? d_target : pc + PC_W'(1);
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pc          = pc;
  assign bus.RFSrcMuxSel = exec ? d_rfsel  : 1'b0;
  assign bus.RAddr1      = exec ? d_raddr1 : '0;
  assign bus.RAddr2      = exec ? d_raddr2 : '0;
  assign bus.WAddr       = exec ? d_waddr  : '0;
  assign bus.ALUop       = exec ? d_aluop  : '0;
  assign bus.we          = retire & d_we;
  assign bus.OutPortEn   = retire & d_oe;

endmodule

// File: tb/tb_ucode_control_unit.sv
// Directed bench for ucode_control_unit: per-cycle vector table plus reset/abort/guard/step sequences.
module tb_ucode_control_unit;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  ucode_control_unit_if u_if ();

  ucode_control_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        lte;
    logic        zero;
    bit          pc_dc;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl [22];

  function automatic logic [17:0] enc(input logic [2:0] op, input logic [2:0] w,
                                      input logic [2:0] r1, input logic [2:0] r2,
                                      input logic [1:0] alu, input logic [3:0] tgt);
    return {op, w, r1, r2, alu, tgt};
  endfunction

  // {busy, done, pc, RFSrcMuxSel, WAddr, RAddr1, RAddr2, we, OutPortEn, ALUop}
  function automatic logic [19:0] mk(input bit b, input bit d, input logic [3:0] p,
                                     input bit rf, input logic [2:0] wa, input logic [2:0] ra1,
                                     input logic [2:0] ra2, input bit w, input bit oe,
                                     input logic [1:0] alu);
    return {b, d, p, rf, wa, ra1, ra2, w, oe, alu};
  endfunction

  function automatic vec_t row(input logic s, input logic l, input logic z, input bit dc,
                               input logic [19:0] e);
    vec_t v;
    v.start = s;
    v.lte   = l;
    v.zero  = z;
    v.pc_dc = dc;
    v.exp   = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [19:0] exp, input bit pc_dc);
    logic [19:0] act;
    logic [19:0] m;
    act = {u_if.busy, u_if.done, u_if.pc, u_if.RFSrcMuxSel, u_if.WAddr, u_if.RAddr1,
           u_if.RAddr2, u_if.we, u_if.OutPortEn, u_if.ALUop};
    m = pc_dc ? 20'hC3FFF : 20'hFFFFF;
    checks++;
    if ((act & m) !== (exp & m)) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h (mask %05h)", nm, act, exp, m);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [17:0] d);
    u_if.prog_we    = 1'b1;
    u_if.prog_addr  = a;
    u_if.prog_wdata = d;
    tick();
    u_if.prog_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] nopw;
    logic [17:0] r_ldi, r_alu, r_out, r_nop, r_bz, r_halt, r_jmp, r_blte;
    logic [19:0] r_pc0, r_pc1, r_pc2, r_pc3, r_pc4, r_bzo, r_idle, r_done;

    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    u_if.start      = 1'b0;
    u_if.abort      = 1'b0;
    u_if.prog_we    = 1'b0;
    u_if.prog_addr  = '0;
    u_if.prog_wdata = '0;
    u_if.lte        = 1'b0;
    u_if.zero       = 1'b0;
`ifdef UCODE_STEP_EN
    u_if.step       = 1'b1;
`endif

    // Unused fields are filled with junk so unused outputs must be forced to 0.
    r_ldi  = enc(3'd1, 3'd1, 3'd7, 3'd7, 2'd3, 4'd5);
    r_alu  = enc(3'd2, 3'd2, 3'd1, 3'd1, 2'd0, 4'd6);
    r_out  = enc(3'd3, 3'd5, 3'd2, 3'd6, 2'd3, 4'd1);
    r_blte = enc(3'd4, 3'd4, 3'd1, 3'd2, 2'd2, 4'd0);
    r_jmp  = enc(3'd6, 3'd7, 3'd7, 3'd7, 2'd3, 4'd9);
    r_nop  = enc(3'd0, 3'd7, 3'd7, 3'd7, 2'd3, 4'd2);
    r_bz   = enc(3'd5, 3'd6, 3'd3, 3'd5, 2'd3, 4'd15);
    r_halt = enc(3'd7, 3'd7, 3'd7, 3'd7, 2'd3, 4'd0);
    nopw   = r_nop;

    r_pc0  = mk(1, 0, 4'd0, 1, 3'd1, 3'd0, 3'd0, 1, 0, 2'd0);
    r_pc1  = mk(1, 0, 4'd1, 0, 3'd2, 3'd1, 3'd1, 1, 0, 2'd0);
    r_pc2  = mk(1, 0, 4'd2, 0, 3'd0, 3'd2, 3'd0, 0, 1, 2'd0);
    r_pc3  = mk(1, 0, 4'd3, 0, 3'd0, 3'd1, 3'd2, 0, 0, 2'd0);
    r_pc4  = mk(1, 0, 4'd4, 0, 3'd0, 3'd0, 3'd0, 0, 0, 2'd0);
    r_bzo  = mk(1, 0, 4'd9, 0, 3'd0, 3'd3, 3'd5, 0, 0, 2'd3);
    r_idle = mk(0, 0, 4'd0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 2'd0);
    r_done = mk(0, 1, 4'd0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 2'd0);

    tbl[0]  = row(1, 0, 0, 0, r_idle);
    tbl[1]  = row(0, 0, 0, 0, r_pc0);
    tbl[2]  = row(1, 0, 0, 0, r_pc1);
    tbl[3]  = row(0, 0, 0, 0, r_pc2);
    tbl[4]  = row(0, 1, 0, 0, r_pc3);
    tbl[5]  = row(0, 0, 0, 0, r_pc0);
    tbl[6]  = row(0, 0, 0, 0, r_pc1);
    tbl[7]  = row(0, 0, 0, 0, r_pc2);
    tbl[8]  = row(0, 0, 1, 0, r_pc3);
    tbl[9]  = row(0, 0, 0, 0, r_pc4);
    tbl[10] = row(0, 0, 1, 0, r_bzo);
    tbl[11] = row(0, 0, 0, 0, mk(1, 0, 4'd15, 0, 3'd0, 3'd0, 3'd0, 0, 0, 2'd0));
    tbl[12] = row(0, 0, 0, 0, r_pc0);
    tbl[13] = row(0, 0, 0, 0, r_pc1);
    tbl[14] = row(0, 0, 0, 0, r_pc2);
    tbl[15] = row(0, 0, 1, 0, r_pc3);
    tbl[16] = row(0, 0, 0, 0, r_pc4);
    tbl[17] = row(0, 1, 0, 0, r_bzo);
    tbl[18] = row(0, 0, 0, 0, mk(1, 0, 4'd10, 0, 3'd0, 3'd0, 3'd0, 0, 0, 2'd0));
    tbl[19] = row(1, 0, 0, 1, r_done);
    tbl[20] = row(0, 0, 0, 1, r_idle);
    tbl[21] = row(0, 0, 0, 1, r_idle);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", r_idle, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    load(4'd0, r_ldi);
    load(4'd1, r_alu);
    load(4'd2, r_out);
    load(4'd3, r_blte);
    load(4'd4, r_jmp);
    for (int a = 5; a < 9; a++) load(4'(a), r_nop);
    load(4'd9, r_bz);
    load(4'd10, r_halt);
    for (int a = 11; a < 16; a++) load(4'(a), r_nop);

    for (int i = 0; i < 22; i++) begin
      u_if.start = tbl[i].start;
      u_if.lte   = tbl[i].lte;
      u_if.zero  = tbl[i].zero;
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp, tbl[i].pc_dc);
      tick();
    end
    u_if.start = 1'b0;
    u_if.lte   = 1'b0;
    u_if.zero  = 1'b0;

    // Straight-line program; word 3 rewritten in the same cycle as start.
    load(4'd4, nopw);
    u_if.prog_we    = 1'b1;
    u_if.prog_addr  = 4'd3;
    u_if.prog_wdata = nopw;
    u_if.start      = 1'b1;
    tick();
    u_if.start      = 1'b0;
    u_if.prog_addr  = 4'd2;
    u_if.prog_wdata = r_halt;
    @(negedge clk);
    check("run_pc0", r_pc0, 0);
    tick();
    u_if.prog_we = 1'b0;
    tick();
    @(negedge clk);
    check("busy_write_ignored", r_pc2, 0);
    tick();
    @(negedge clk);
    check("write_with_start", mk(1, 0, 4'd3, 0, 3'd0, 3'd0, 3'd0, 0, 0, 2'd0), 0);
    tick();
    tick();
    @(negedge clk);
    check("reach_pc5", mk(1, 0, 4'd5, 0, 3'd0, 3'd0, 3'd0, 0, 0, 2'd0), 0);
    reset_n = 1'b0;
    #1;
    check("async_reset", r_idle, 0);
    tick();
    check("reset_hold", r_idle, 0);
    reset_n = 1'b1;

    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    @(negedge clk);
    check("store_kept", r_pc0, 0);
    repeat (7) tick();
    u_if.abort = 1'b1;
    @(negedge clk);
    check("abort_cycle", mk(1, 0, 4'd7, 0, 3'd0, 3'd0, 3'd0, 0, 0, 2'd0), 0);
    tick();
    u_if.abort = 1'b0;
    @(negedge clk);
    check("abort_idle", r_idle, 1);
    tick();
    @(negedge clk);
    check("abort_no_done", r_idle, 1);
    tick();

`ifdef UCODE_STEP_EN
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    tick();
    u_if.step = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("step_hold%0d", k), mk(1, 0, 4'd1, 0, 3'd2, 3'd1, 3'd1, 0, 0, 2'd0), 0);
      tick();
    end
    u_if.step = 1'b1;
    @(negedge clk);
    check("step_go", r_pc1, 0);
    tick();
    @(negedge clk);
    check("step_adv", r_pc2, 0);
    u_if.abort = 1'b1;
    tick();
    u_if.abort = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucode_control_unit.md
Name: ucode_control_unit

Overview:
- Programmable successor to the hardwired register-file/ALU control FSM.
- Executes one micro-instruction per clock from an internal, loadable program store.
- Drives the same datapath control set: RFSrcMuxSel, RAddr1/2, WAddr, we, OutPortEn, ALUop. Branches on the datapath lte/zero flags.
- Register-address width, ALU-op width and program depth are parameters; start/busy/done handshake and abort are new.

Parameters:
- REG_ADDR_W, 3, register-file address width.
- ALUOP_W, 2, ALU opcode width.
- PROG_DEPTH, 16, program store entries; must be a power of 2, ≥2.
- PC_W, $clog2(PROG_DEPTH), program counter width (derived, not overridden).
- INSTR_W, 3+3*REG_ADDR_W+ALUOP_W+PC_W, instruction width (derived; default 18).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution at pc=0 (sampled in IDLE only).
- abort  in  1  stop execution and return to IDLE.
- prog_we  in  1  program store write strobe.
- prog_addr  in  PC_W  program store write address.
- prog_wdata  in  INSTR_W  instruction word.
- lte  in  1  datapath flag: RAddr1 operand <= RAddr2 operand (same-cycle combinational).
- zero  in  1  datapath flag: ALU result == 0 (same-cycle combinational).
- busy  out  1  high in EXEC.
- done  out  1  one-cycle pulse on HALT retirement.
- pc  out  PC_W  current program counter.
- RFSrcMuxSel  out  1  1 = write constant 1; 0 = write ALU result.
- RAddr1, RAddr2, WAddr  out  REG_ADDR_W each  register-file addresses.
- we  out  1  register-file write enable.
- OutPortEn  out  1  output-port load enable.
- ALUop  out  ALUOP_W  ALU operation.

Behaviour:
- Instruction fields, MSB→LSB: op[2:0], waddr, raddr1, raddr2, aluop, target[PC_W-1:0].
- Opcodes:
  - 0 NOP: no effect.
  - 1 LDI1: RFSrcMuxSel=1, we=1, WAddr=waddr.
  - 2 ALU: we=1, all fields driven.
  - 3 OUT: OutPortEn=1, RAddr1=raddr1.
  - 4 BLTE: drive raddr1/raddr2, we=0; branch to target if lte.
  - 5 BZ: drive raddr1/raddr2/aluop, we=0; branch if zero.
  - 6 JMP: unconditional branch to target.
  - 7 HALT.
- FSM states:
  - IDLE: all control outputs 0, busy=0. start=1 → EXEC, pc←0.
  - EXEC: decode store[pc] combinationally and drive outputs this cycle. Next pc is target on a taken branch or JMP, else pc+1. pc wraps PROG_DEPTH-1 → 0. HALT → DONE.
  - DONE: done=1 and control outputs 0 for one cycle, then IDLE.
- Latency: start seen at edge N puts instruction 0 on the outputs in cycle N+1. Throughput is 1 instruction/cycle, branches included (no bubble).
- abort has priority over everything in EXEC: the current cycle's outputs still drive, next state is IDLE, no done pulse. abort in IDLE or DONE is ignored.
- start while busy or in DONE is ignored.
- Program store writes:
  - Accepted only when state==IDLE; ignored otherwise.
  - A write and a start in the same IDLE cycle: the write lands, and execution sees the new word.
  - Store contents are not reset and have no read latency (flop array, async read).
- Reset (reset_n=0, any time including mid-program): state=IDLE, pc=0, busy=0, done=0, all control outputs 0. Store contents are preserved.
- Unused fields are don't-care but must still drive 0 on unused outputs per opcode.

Optional Feature:
- Macro: UCODE_STEP_EN.
- Defined: adds input step (1 bit). In EXEC an instruction retires only in cycles with step=1. In cycles with step=0:
  - outputs show the decode with we=0 and OutPortEn=0;
  - pc holds;
  - abort still acts.
- Undefined: no step port; every EXEC cycle retires.

Decomposition:
- Package ucode_pkg: opcode enum op_e (NOP…HALT), state enum {IDLE, EXEC, DONE}, and field-offset localparams derived from the parameters.
- Sub-module ucode_decoder: purely combinational, instruction + flags → control outputs, branch_taken, is_halt. The top keeps the FSM, pc and program store.

Test Plan:
- Reset then idle: reset_n low mid-EXEC at pc=5 → next cycle busy=0, pc=0, we=0, OutPortEn=0. Store word 0 is unchanged on re-run.
- Linear program [LDI1 W1; ALU W2=R1+R1 op0; OUT R2; HALT], start pulse:
  - cycle1 we=1, RFSrcMuxSel=1, WAddr=1;
  - cycle2 RAddr1=1, RAddr2=1, WAddr=2;
  - cycle3 OutPortEn=1, RAddr1=2;
  - cycle4 busy=1 (HALT);
  - cycle5 done=1;
  - cycle6 idle.
- Branch: BLTE target=0 at pc=3. lte=1 → pc=0 next cycle; lte=0 → pc=4. Confirm no bubble cycle in either case.
- Wrap/JMP: PROG_DEPTH=16, NOP at pc=15 → pc=0. JMP target=9 → pc=9.
- Handshake guards: prog_we while busy at addr 2 → store unchanged. start during EXEC → no restart. abort at pc=7 → IDLE with no done pulse.
- UCODE_STEP_EN: step low for 3 cycles on an ALU word → we=0, pc held. Step high → we=1, pc+1.
